// File: rtl/fetch_pc_if.sv
// Handshake bundle between the fetch/PC stage and its environment (control
// inputs in, fetch address and status out).
interface fetch_pc_if #(
    parameter int PC_W = 10
);
    logic            start;
    logic            stall;
    logic            branchCompPass;
    logic [7:0]      branchOffset;
    logic            halt;
    logic [PC_W-1:0] pc;
    logic            instrValid;
    logic            done;
    logic [15:0]     instrCount;

    modport master (
        output start, stall, branchCompPass, branchOffset, halt,
        input  pc, instrValid, done, instrCount
    );

    modport slave (
        input  start, stall, branchCompPass, branchOffset, halt,
        output pc, instrValid, done, instrCount
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter / fetch sequencer: start, stall, halt, taken-branch redirect with one squash bubble.
// Optional retired-instruction counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_pc_unit #(
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] START_ADDR = {PC_W{1'b0}}
) (
    input  logic       clk,
    input  logic       rst_n,
    fetch_pc_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_BUBBLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q;
    logic            done_q;
    logic [PC_W-1:0] branch_tgt_s;
    logic [PC_W-1:0] pc_inc_s;

    // Offset is measured from the branch's own pc; PC_W must exceed 8.
    assign branch_tgt_s = pc_q + {{(PC_W-8){bus.branchOffset[7]}}, bus.branchOffset};
    assign pc_inc_s     = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

    // Next-state and next-pc selection; a stall freezes everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (!bus.stall) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        pc_d    = START_ADDR;
                        state_d = ST_RUN;
                    end else begin
                        pc_d    = pc_q;
                    end
                end
                ST_RUN: begin
                    if (bus.halt) begin
                        state_d = ST_DONE;
                    end else if (bus.branchCompPass) begin
                        pc_d    = branch_tgt_s;
                        state_d = ST_BUBBLE;
                    end else begin
                        pc_d    = pc_inc_s;
                    end
                end
                ST_BUBBLE: begin
                    pc_d    = pc_inc_s;
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, pc and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= {PC_W{1'b0}};
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign bus.pc         = pc_q;
    assign bus.instrValid = valid_q;
    assign bus.done       = done_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] count_q;

    // Counts every unstalled RUN cycle, including the branch/halt cycle; saturates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 16'h0000;
        end else if (!bus.stall && bus.start &&
                     ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
            count_q <= 16'h0000;
        end else if (!bus.stall && (state_q == ST_RUN) && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'h0001;
        end else begin
            count_q <= count_q;
        end
    end

    assign bus.instrCount = count_q;
`else
    assign bus.instrCount = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit (PC_W=10, START_ADDR=0).
module tb_fetch_pc_unit;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_pc_if #(.PC_W(10)) bus ();

    fetch_pc_unit #(.PC_W(10), .START_ADDR(10'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input logic [9:0] tgt, input string name);
        int n;
        n = 0;
        while (bus.pc !== tgt && n < 1100) begin
            tick();
            n++;
        end
        checks++;
        if (bus.pc !== tgt) begin
            errors++;
            $display("FAIL %s: pc=%0d, wanted to reach %0d within budget", name, bus.pc, tgt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.stall = 1'b0; bus.branchCompPass = 1'b0;
        bus.branchOffset = 8'h00; bus.halt = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.pc, bus.instrValid, bus.done, bus.instrCount} !== {10'd0, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset: pc=%0d v=%0b d=%0b cnt=%0d want 0 0 0 0",
                     bus.pc, bus.instrValid, bus.done, bus.instrCount);
        end
        rst_n = 1'b1;
        bus.branchCompPass = 1'b1;
        tick();
        tick();
        bus.branchCompPass = 1'b0;
        checks++;
        if ({bus.pc, bus.instrValid, bus.done} !== {10'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL idle_hold: pc=%0d v=%0b d=%0b want 0 0 0", bus.pc, bus.instrValid, bus.done);
        end
    endtask

    task automatic test_sequential();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            checks++;
            if ({bus.pc, bus.instrValid, bus.done} !== {i[9:0], 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL seq_%0d: pc=%0d v=%0b d=%0b want pc=%0d v=1 d=0",
                         i, bus.pc, bus.instrValid, bus.done, i);
            end
        end
    endtask

    task automatic test_branch_back();
        run_to(10'd20, "reach_20");
        bus.branchCompPass = 1'b1; bus.branchOffset = 8'hFB;
        tick();
        bus.branchCompPass = 1'b0; bus.start = 1'b1;
        checks++;
        if ({bus.pc, bus.instrValid} !== {10'd15, 1'b0}) begin
            errors++;
            $display("FAIL br_back_bubble: pc=%0d v=%0b want pc=15 v=0", bus.pc, bus.instrValid);
        end
        tick();
        bus.start = 1'b0;
        checks++;
        if ({bus.pc, bus.instrValid} !== {10'd16, 1'b1}) begin
            errors++;
            $display("FAIL br_back_resume: pc=%0d v=%0b want pc=16 v=1", bus.pc, bus.instrValid);
        end
    endtask

    task automatic test_stall_branch();
        bus.branchCompPass = 1'b1; bus.branchOffset = 8'hF6;
        tick();
        bus.branchCompPass = 1'b0;
        tick();
        checks++;
        if ({bus.pc, bus.instrValid} !== {10'd7, 1'b1}) begin
            errors++;
            $display("FAIL reach_7: pc=%0d v=%0b want pc=7 v=1", bus.pc, bus.instrValid);
        end
        bus.stall = 1'b1; bus.branchCompPass = 1'b1; bus.branchOffset = 8'd10;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.pc, bus.instrValid} !== {10'd7, 1'b1}) begin
                errors++;
                $display("FAIL stall_%0d: pc=%0d v=%0b want pc=7 v=1", i, bus.pc, bus.instrValid);
            end
        end
        bus.stall = 1'b0;
        tick();
        bus.branchCompPass = 1'b0;
        checks++;
        if ({bus.pc, bus.instrValid} !== {10'd17, 1'b0}) begin
            errors++;
            $display("FAIL stall_br_taken: pc=%0d v=%0b want pc=17 v=0", bus.pc, bus.instrValid);
        end
        tick();
        checks++;
        if ({bus.pc, bus.instrValid} !== {10'd18, 1'b1}) begin
            errors++;
            $display("FAIL stall_br_resume: pc=%0d v=%0b want pc=18 v=1", bus.pc, bus.instrValid);
        end
    endtask

    task automatic test_halt();
        run_to(10'd30, "reach_30");
        bus.halt = 1'b1; bus.branchCompPass = 1'b1; bus.branchOffset = 8'd5;
        tick();
        bus.halt = 1'b0; bus.branchCompPass = 1'b0;
        tick();
        checks++;
        if ({bus.pc, bus.instrValid, bus.done} !== {10'd30, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL halt_done: pc=%0d v=%0b d=%0b want pc=30 v=0 d=1",
                     bus.pc, bus.instrValid, bus.done);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if ({bus.pc, bus.instrValid, bus.done} !== {10'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL restart: pc=%0d v=%0b d=%0b want pc=0 v=1 d=0",
                     bus.pc, bus.instrValid, bus.done);
        end
    endtask

    task automatic test_wrap();
        run_to(10'd1023, "reach_1023");
        tick();
        checks++;
        if ({bus.pc, bus.instrValid} !== {10'd0, 1'b1}) begin
            errors++;
            $display("FAIL wrap_up: pc=%0d v=%0b want pc=0 v=1", bus.pc, bus.instrValid);
        end
        tick();
        tick();
        bus.branchCompPass = 1'b1; bus.branchOffset = 8'h80;
        tick();
        bus.branchCompPass = 1'b0;
        checks++;
        if ({bus.pc, bus.instrValid} !== {10'd898, 1'b0}) begin
            errors++;
            $display("FAIL wrap_neg: pc=%0d v=%0b want pc=898 v=0", bus.pc, bus.instrValid);
        end
        tick();
    endtask

    task automatic test_reset_in_bubble();
        bus.branchCompPass = 1'b1; bus.branchOffset = 8'd3;
        tick();
        bus.branchCompPass = 1'b0;
        checks++;
        if ({bus.pc, bus.instrValid} !== {10'd902, 1'b0}) begin
            errors++;
            $display("FAIL pre_rst_bubble: pc=%0d v=%0b want pc=902 v=0", bus.pc, bus.instrValid);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({bus.pc, bus.instrValid, bus.done} !== {10'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_bubble: pc=%0d v=%0b d=%0b want pc=0 v=0 d=0",
                     bus.pc, bus.instrValid, bus.done);
        end
    endtask

    task automatic test_perf_count();
        logic [15:0] exp_cnt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                bus.stall = 1'b1;
                tick();
                bus.stall = 1'b0;
            end
            tick();
        end
        exp_cnt = PERF ? 16'd10 : 16'd0;
        checks++;
        if ({bus.pc, bus.instrCount} !== {10'd10, exp_cnt}) begin
            errors++;
            $display("FAIL perf_run: pc=%0d cnt=%0d want pc=10 cnt=%0d", bus.pc, bus.instrCount, exp_cnt);
        end
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        tick();
        exp_cnt = PERF ? 16'd11 : 16'd0;
        checks++;
        if ({bus.done, bus.instrCount} !== {1'b1, exp_cnt}) begin
            errors++;
            $display("FAIL perf_halt: d=%0b cnt=%0d want d=1 cnt=%0d", bus.done, bus.instrCount, exp_cnt);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if ({bus.instrValid, bus.instrCount} !== {1'b1, 16'd0}) begin
            errors++;
            $display("FAIL perf_clear: v=%0b cnt=%0d want v=1 cnt=0", bus.instrValid, bus.instrCount);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        test_reset();
        test_sequential();
        test_branch_back();
        test_stall_branch();
        test_halt();
        test_wrap();
        test_reset_in_bubble();
        test_perf_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
